dm_wb_stage: RTL
================

// Module: dm_wb_stage
// PURPOSE
//  Data-memory access stage plus DM/WB pipeline register. Sits directly downstream
//  of the EXE/DM register, consuming its control, ALU result, store data and dest addr.
//  Performs word loads/stores on an internal data RAM with a configurable access
//  latency. Stalls the upstream pipeline while an access is in flight, then registers
//  the write-back value, write enable and destination address for the WB stage.
// PARAMETERS
//  DSIZE    32  data width (bits)
//  ASIZE    5   register-file address width
//  MADDR    8   data-RAM word-address width (2**MADDR words)
//  MEM_LAT  2   cycles per memory access, >=1 (1 = single-cycle, no stall)
// PORTS
//  clk            in   1      clock, all state updates on posedge
//  rst            in   1      reset, synchronous, active-high
//  wen_in         in   1      reg-file write enable from EXE/DM
//  mem_read_in    in   1      load request
//  mem_write_in   in   1      store request
//  mem_to_reg_in  in   1      1: write back load data, 0: write back ALU result
//  waddr_in       in   ASIZE  destination register
//  aluout_in      in   DSIZE  ALU result / byte address for load/store
//  wdata_in       in   DSIZE  store data (rt value)
//  stall_out      out  1      hold request to PC/IF/ID/EXE/EXE-DM registers
//  wen_out        out  1      registered reg-file write enable to WB
//  waddr_out      out  ASIZE  registered destination register
//  wb_data_out    out  DSIZE  registered write-back data
// BEHAVIOUR
//  Reset: rst synchronous, active-high; clock clk. On rst: wen_out=0, waddr_out=0,
//   wb_data_out=0, access counter cnt=0. RAM contents are NOT cleared by rst.
//  Addressing: word index = aluout_in[MADDR+1:2]; aluout_in[1:0] ignored; upper bits
//   ignored (addresses alias modulo 2**MADDR words).
//  mem_op = mem_read_in | mem_write_in.
//  Counter cnt, width clog2(MEM_LAT)+1; states IDLE (cnt=0) / BUSY (cnt>0).
//  stall_out (combinational) = mem_op & (cnt != MEM_LAT-1). Never high when MEM_LAT=1
//   or when mem_op=0.
//  Stall cycle (stall_out=1): cnt<=cnt+1; RAM not written; DM/WB register loads a
//   bubble: wen_out<=0, waddr_out<=0, wb_data_out<=0. Upstream holds inputs stable.
//  Completion edge (mem_op=1, cnt==MEM_LAT-1): store writes RAM[idx]<=wdata_in
//   exactly once; load samples RAM[idx]; cnt<=0; DM/WB register loads instruction.
//  Non-memory instruction (mem_op=0): 1-cycle pass-through, cnt stays 0.
//  DM/WB load: wen_out<=wen_in; waddr_out<=waddr_in;
//   wb_data_out<= mem_to_reg_in ? RAM[idx] (pre-edge value) : aluout_in.
//  Total latency input->output: MEM_LAT cycles for loads/stores, 1 cycle otherwise.
//  Back-to-back memory ops: each takes full MEM_LAT cycles; cnt restarts from 0.
//  mem_read_in & mem_write_in both 1: store performed; load data is old contents
//   (read-before-write).
//  mem_op drops mid-access (upstream flush): cnt<=0 next edge, no RAM write, entry
//   treated as non-memory instruction.
//  rst mid-access: pending store aborted (RAM unchanged), cnt<=0, outputs zeroed.
//  wen_out is passed through as given; waddr 0 suppression is the reg-file's job.
// TESTING
//  T1 MEM_LAT=1: store 0xDEADBEEF @0x10, then load @0x10 mem_to_reg=1 waddr=3 ->
//     no stall; 2nd output wen=1 waddr=3 wb_data=0xDEADBEEF.
//  T2 MEM_LAT=3: load @0x10 held -> stall_out=1,1,0 over 3 cycles; 2 bubble outputs
//     (wen_out=0) then wb_data=0xDEADBEEF; store counts exactly one RAM write.
//  T3 ALU op aluout=0x1234 wen=1 waddr=7 mem_to_reg=0 -> next cycle wb_data=0x1234,
//     waddr=7, stall_out never asserted.
//  T4 Alias/alignment: store 0xA5A5A5A5 @0x13 (MADDR=8), load @0x410 -> 0xA5A5A5A5.
//  T5 MEM_LAT=3: store 0x11 @0x20 after prior 0x22; rst on 2nd stall cycle -> outputs
//     0, cnt 0; later load @0x20 returns 0x22.
//  T6 Read+write same cycle @0x30 (old 0x5, new 0x9) -> wb_data=0x5; next load -> 0x9.

Source files
------------

// File: rtl/dm_wb_stage.sv
// rtl/dm_wb_stage.sv - data-memory access stage with DM/WB pipeline register
// Word RAM with MEM_LAT-cycle access; stalls upstream until the access completes.
module dm_wb_stage #(
   parameter int DSIZE   = 32,
   parameter int ASIZE   = 5,
   parameter int MADDR   = 8,
   parameter int MEM_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen_in,
   input  logic             mem_read_in,
   input  logic             mem_write_in,
   input  logic             mem_to_reg_in,
   input  logic [ASIZE-1:0] waddr_in,
   input  logic [DSIZE-1:0] aluout_in,
   input  logic [DSIZE-1:0] wdata_in,
   output logic             stall_out,
   output logic             wen_out,
   output logic [ASIZE-1:0] waddr_out,
   output logic [DSIZE-1:0] wb_data_out
);

   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   logic [DSIZE-1:0] mem [0:(2**MADDR)-1];
   logic [MADDR-1:0] idx;
   logic [DSIZE-1:0] rd_data;
   logic [CW-1:0]    cnt, cnt_next;
   logic             mem_op, done;

   // Byte-offset and high address bits are don't-care; addresses alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{aluout_in[1:0], aluout_in[DSIZE-1:MADDR+2]};

   assign idx     = aluout_in[MADDR+1:2];
   assign rd_data = mem[idx];
   assign mem_op  = mem_read_in | mem_write_in;
   assign done    = mem_op & (cnt == LAST);

   always_comb begin
      stall_out = 1'b0;
      cnt_next  = '0;
      if (mem_op && !done) begin
         stall_out = 1'b1;
         cnt_next  = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         wen_out     <= 1'b0;
         waddr_out   <= '0;
         wb_data_out <= '0;
      end else begin
         cnt <= cnt_next;
         if (stall_out) begin
            wen_out     <= 1'b0;
            waddr_out   <= '0;
            wb_data_out <= '0;
         end else begin
            wen_out     <= wen_in;
            waddr_out   <= waddr_in;
            wb_data_out <= mem_to_reg_in ? rd_data : aluout_in;
         end
      end
   end

   // Store commits only on the completion edge, so a reset or flush mid-access drops it.
   always_ff @(posedge clk) begin
      if (!rst && done && mem_write_in)
         mem[idx] <= wdata_in;
   end

endmodule
